// File: rtl/parking_billing_ctrl_pkg.sv
// Shared definitions for the parking billing controller and the per-car store.
package parking_billing_ctrl_pkg;

  localparam int TIME_W_DEF = 10;
  localparam int NUM_BAYS   = 3;

  // Sequencer states; IDLE is the only state in which requests are granted.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENT_WR,
    ST_EXT_RD,
    ST_EXT_CALC,
    ST_EXT_WR
  } state_t;

  // One-hot bay selects as seen by the store.
  localparam logic [NUM_BAYS-1:0] CAR1 = 3'b001;
  localparam logic [NUM_BAYS-1:0] CAR2 = 3'b010;
  localparam logic [NUM_BAYS-1:0] CAR3 = 3'b100;

  // Converts a one-hot bay select into a 0-based bay index.
  function automatic logic [1:0] onehot_to_idx(input logic [NUM_BAYS-1:0] oh);
    case (oh)
      CAR2:    return 2'd1;
      CAR3:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // Fixed-priority pick: car1 beats car2 beats car3.
  function automatic logic [NUM_BAYS-1:0] pick_first(input logic [NUM_BAYS-1:0] v);
    if (v[0])      return CAR1;
    else if (v[1]) return CAR2;
    else if (v[2]) return CAR3;
    return '0;
  endfunction

endpackage

// File: rtl/parking_billing_ctrl_fee_calc.sv
// Fee arithmetic: wrap-around parking duration times rate, saturated at a ceiling.
module parking_billing_ctrl_fee_calc #(
  parameter int RATE     = 2,
  parameter int TIME_W   = 10,
  parameter int MAX_COST = 1023
) (
  input  logic [TIME_W-1:0] t_exit,
  input  logic [TIME_W-1:0] t_entry,
  output logic [TIME_W-1:0] cost
);

  localparam int PROD_W = TIME_W + 4;
  localparam logic [PROD_W-1:0] RATE_W = PROD_W'(RATE);
  localparam logic [PROD_W-1:0] CEIL_W = PROD_W'(MAX_COST);

  logic [TIME_W-1:0] dur;
  logic [PROD_W-1:0] prod;

  // Subtraction at TIME_W bits wraps naturally when the tick counter rolled over.
  always_comb begin
    dur  = t_exit - t_entry;
    prod = PROD_W'(dur) * RATE_W;
    cost = (prod > CEIL_W) ? CEIL_W[TIME_W-1:0] : prod[TIME_W-1:0];
  end

endmodule

// File: rtl/parking_billing_ctrl.sv
// Sequences entry/exit requests for three bays into store writes and fee reports.
module parking_billing_ctrl
  import parking_billing_ctrl_pkg::*;
#(
  parameter int RATE     = 2,
  parameter int TIME_W   = TIME_W_DEF,
  parameter int MAX_COST = 1023
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [TIME_W-1:0]   time_now,
  input  logic [NUM_BAYS-1:0] entry_req,
  input  logic [NUM_BAYS-1:0] exit_req,
  input  logic [TIME_W-1:0]   entry_time_rd,
  output logic [NUM_BAYS-1:0] car_sel,
  output logic                write_entry,
  output logic                write_cost,
  output logic [TIME_W-1:0]   entry_time_wr,
  output logic [TIME_W-1:0]   cost_wr,
  output logic [NUM_BAYS-1:0] occupied,
  output logic                busy,
  output logic                fee_valid,
  output logic [TIME_W-1:0]   fee,
  output logic                req_err
);

  state_t              state_q, state_d;
  logic [NUM_BAYS-1:0] entry_pend_q, exit_pend_q;
  logic [NUM_BAYS-1:0] entry_clr, exit_clr;
  logic [NUM_BAYS-1:0] grant_oh;
  logic                grant_valid, grant_is_exit, grant_legal;
  logic [NUM_BAYS-1:0] car_sel_q, occupied_q;
  logic [TIME_W-1:0]   t_cap_q, entry_reg_q, cost_q, calc_cost;
  logic                req_err_q;

  // Arbitrate pending requests in IDLE and compute the next state.
  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    grant_oh      = '0;
    grant_valid   = 1'b0;
    grant_is_exit = 1'b0;
    grant_legal   = 1'b0;
    entry_clr     = '0;
    exit_clr      = '0;

    if (state_q == ST_IDLE) begin
      if (|exit_pend_q) begin
        grant_valid   = 1'b1;
        grant_is_exit = 1'b1;
        grant_oh      = pick_first(exit_pend_q);
        grant_legal   = |(grant_oh & occupied_q);
        exit_clr      = grant_oh;
      end else if (|entry_pend_q) begin
        grant_valid   = 1'b1;
        grant_oh      = pick_first(entry_pend_q);
        grant_legal   = ~|(grant_oh & occupied_q);
        entry_clr     = grant_oh;
      end
    end

    case (state_q)
      ST_IDLE:     if (grant_valid && grant_legal)
                     state_d = grant_is_exit ? ST_EXT_RD : ST_ENT_WR;
      ST_ENT_WR:   state_d = ST_IDLE;
      ST_EXT_RD:   state_d = ST_EXT_CALC;
      ST_EXT_CALC: state_d = ST_EXT_WR;
      ST_EXT_WR:   state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Pending request capture; a grant clears its bit and swallows a same-cycle repeat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry_pend_q <= '0;
      exit_pend_q  <= '0;
    end else begin
      entry_pend_q <= (entry_pend_q | entry_req) & ~entry_clr;
      exit_pend_q  <= (exit_pend_q  | exit_req)  & ~exit_clr;
    end
  end

  parking_billing_ctrl_fee_calc #(
    .RATE     (RATE),
    .TIME_W   (TIME_W),
    .MAX_COST (MAX_COST)
  ) u_fee_calc (
    .t_exit  (t_cap_q),
    .t_entry (entry_reg_q),
    .cost    (calc_cost)
  );

  // Datapath: latch bay and time at grant, read entry time, hold cost, track occupancy.
  // The cost register also drives the fee output, so the fee is already stable
  // during the fee_valid pulse and then holds until the next exit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      car_sel_q   <= '0;
      t_cap_q     <= '0;
      entry_reg_q <= '0;
      cost_q      <= '0;
      occupied_q  <= '0;
      req_err_q   <= 1'b0;
    end else begin
      req_err_q <= grant_valid && !grant_legal;
      case (state_q)
        ST_IDLE: begin
          if (grant_valid && grant_legal) begin
            car_sel_q <= grant_oh;
            t_cap_q   <= time_now;
          end
        end
        ST_ENT_WR: begin
          occupied_q <= occupied_q | car_sel_q;
          car_sel_q  <= '0;
        end
        ST_EXT_RD:   entry_reg_q <= entry_time_rd;
        ST_EXT_CALC: cost_q      <= calc_cost;
        ST_EXT_WR: begin
          occupied_q <= occupied_q & ~car_sel_q;
          car_sel_q  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign car_sel       = car_sel_q;
  assign write_entry   = (state_q == ST_ENT_WR);
  assign write_cost    = (state_q == ST_EXT_WR);
  assign fee_valid     = (state_q == ST_EXT_WR);
  assign entry_time_wr = t_cap_q;
  assign cost_wr       = cost_q;
  assign fee           = cost_q;
  assign occupied      = occupied_q;
  assign busy          = (state_q != ST_IDLE);
  assign req_err       = req_err_q;

endmodule

// File: tb/tb_parking_billing_ctrl.sv
// Scoreboard bench for parking_billing_ctrl with a behavioural billing model.
`timescale 1ns/1ps
module tb_parking_billing_ctrl;

  localparam int TIME_W   = 10;
  localparam int RATE     = 2;
  localparam int MAX_COST = 1023;
  localparam int WRAP     = 1 << TIME_W;

  logic              clk, reset;
  logic [TIME_W-1:0] time_now;
  logic [2:0]        entry_req, exit_req;
  logic [TIME_W-1:0] entry_time_rd;
  logic [2:0]        car_sel;
  logic              write_entry, write_cost;
  logic [TIME_W-1:0] entry_time_wr, cost_wr;
  logic [2:0]        occupied;
  logic              busy, fee_valid;
  logic [TIME_W-1:0] fee;
  logic              req_err;

  parking_billing_ctrl #(
    .RATE     (RATE),
    .TIME_W   (TIME_W),
    .MAX_COST (MAX_COST)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .time_now      (time_now),
    .entry_req     (entry_req),
    .exit_req      (exit_req),
    .entry_time_rd (entry_time_rd),
    .car_sel       (car_sel),
    .write_entry   (write_entry),
    .write_cost    (write_cost),
    .entry_time_wr (entry_time_wr),
    .cost_wr       (cost_wr),
    .occupied      (occupied),
    .busy          (busy),
    .fee_valid     (fee_valid),
    .fee           (fee),
    .req_err       (req_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple entry-time store behind the controller.
  logic [TIME_W-1:0] store_t [3];
  always_comb begin
    entry_time_rd = '0;
    for (int i = 0; i < 3; i++) if (car_sel[i]) entry_time_rd = store_t[i];
  end
  always @(posedge clk) begin
    if (write_entry)
      for (int i = 0; i < 3; i++) if (car_sel[i]) store_t[i] <= entry_time_wr;
  end

  // Scoreboard.
  typedef enum int {EV_ENT, EV_COST, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       bay;
    int       value;
  } ev_t;
  ev_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: which bays hold a car, their entry times, last fee.
  bit [2:0] ref_occ;
  int       ref_t [3];
  int       ref_fee;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_ev(input ev_kind_t k, input int bay, input int value);
    ev_t e;
    e.kind  = k;
    e.bay   = bay;
    e.value = value;
    exp_q.push_back(e);
  endfunction

  function automatic int lowest(input logic [2:0] v);
    int b = 0;
    for (int i = 2; i >= 0; i--) if (v[i]) b = i;
    return b;
  endfunction

  // Monitor: compare every strobe/error the DUT presents with the oldest expectation.
  always @(negedge clk) begin
    ev_t        e;
    logic [2:0] sel;
    if (reset === 1'b1) begin
      if (write_entry || write_cost || fee_valid) begin
        check("strobe_overlap", write_entry & write_cost, 0);
        check("fee_valid_vs_write_cost", fee_valid, write_cost);
      end
      if (write_entry || write_cost || req_err) begin
        check("event_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e   = exp_q.pop_front();
          sel = 3'b001 << e.bay;
          if (write_entry) begin
            check("event_kind_entry", EV_ENT, e.kind);
            check("entry_car_sel", car_sel, sel);
            check("entry_time_wr", entry_time_wr, e.value);
          end else if (write_cost) begin
            check("event_kind_cost", EV_COST, e.kind);
            check("cost_car_sel", car_sel, sel);
            check("cost_wr", cost_wr, e.value);
            check("fee_at_valid", fee, e.value);
          end else begin
            check("event_kind_err", EV_ERR, e.kind);
            check("err_car_sel", car_sel, 0);
          end
        end
      end
    end
  end

  // Model a batch of simultaneous requests, issue them at a fixed time, let the DUT drain.
  task automatic run_batch(input logic [2:0] ent, input logic [2:0] ext, input int t);
    logic [2:0] x, e;
    int         b, dur, cost, cyc;
    bit         is_exit;
    x = ext;
    e = ent;
    while (x != 0 || e != 0) begin
      is_exit = (x != 0);
      b = is_exit ? lowest(x) : lowest(e);
      if (is_exit) begin
        x[b] = 1'b0;
        if (ref_occ[b]) begin
          dur  = (t - ref_t[b] + WRAP) % WRAP;
          cost = dur * RATE;
          if (cost > MAX_COST) cost = MAX_COST;
          push_ev(EV_COST, b, cost);
          ref_occ[b] = 1'b0;
          ref_fee    = cost;
        end else begin
          push_ev(EV_ERR, b, 0);
        end
      end else begin
        e[b] = 1'b0;
        if (!ref_occ[b]) begin
          push_ev(EV_ENT, b, t);
          ref_occ[b] = 1'b1;
          ref_t[b]   = t;
        end else begin
          push_ev(EV_ERR, b, 0);
        end
      end
    end
    time_now  = t[TIME_W-1:0];
    entry_req = ent;
    exit_req  = ext;
    @(negedge clk);
    entry_req = '0;
    exit_req  = '0;
    cyc = 0;
    while ((exp_q.size() != 0 || busy) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("drain_remaining", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("occupied", occupied, ref_occ);
    check("fee_hold", fee, ref_fee);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset     = 1'b0;
    time_now  = '0;
    entry_req = '0;
    exit_req  = '0;
    ref_occ   = '0;
    ref_fee   = 0;
    for (int i = 0; i < 3; i++) ref_t[i] = 0;

    #12;
    check("rst_car_sel", car_sel, 0);
    check("rst_write_entry", write_entry, 0);
    check("rst_write_cost", write_cost, 0);
    check("rst_occupied", occupied, 0);
    check("rst_busy", busy, 0);
    check("rst_fee_valid", fee_valid, 0);
    check("rst_fee", fee, 0);
    check("rst_req_err", req_err, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic billing, wrap-around, saturation.
    run_batch(3'b001, 3'b000, 100);
    run_batch(3'b000, 3'b001, 130);
    run_batch(3'b010, 3'b000, 1000);
    run_batch(3'b000, 3'b010, 20);
    run_batch(3'b100, 3'b000, 0);
    run_batch(3'b000, 3'b100, 600);
    // Two simultaneous entries, then illegal requests.
    run_batch(3'b101, 3'b000, 50);
    run_batch(3'b001, 3'b010, 60);
    // Entry and exit for the same bay: occupied bay, then free bay.
    run_batch(3'b001, 3'b001, 70);
    run_batch(3'b010, 3'b010, 80);

    // Abort an exit while its fee is being computed.
    if (!ref_occ[1]) run_batch(3'b010, 3'b000, 300);
    time_now = 10'd400;
    exit_req = 3'b010;
    @(negedge clk);
    exit_req = '0;
    cyc = 0;
    while (!busy && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_busy_seen", busy, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_car_sel", car_sel, 0);
    check("abort_write_cost", write_cost, 0);
    check("abort_fee_valid", fee_valid, 0);
    check("abort_fee", fee, 0);
    check("abort_occupied", occupied, 0);
    check("abort_busy", busy, 0);
    exp_q.delete();
    ref_occ = '0;
    ref_fee = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("post_abort_occupied", occupied, 0);
    check("post_abort_busy", busy, 0);

    // Randomised batches.
    for (int n = 0; n < 40; n++)
      run_batch(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), int'($urandom_range(0, WRAP - 1)));

    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
